fx_bus_arb: RTL and testbench

Round-robin arbiter and sequencer for the shared fx register bus. Lets several bus masters (host UART bridge, SPI bridge, on-chip sequencers) take turns issuing single-byte register writes and reads to the module register files (`fetch_reg` and its siblings). Sits between the masters and the fx bus fan-out, and owns `fx_wr`/`fx_rd` timing and `fx_q` capture.

---
 rtl/fx_pkg.sv | 17 +
 rtl/fx_rr_pick.sv | 33 +++
 rtl/fx_bus_arb.sv | 107 ++++++++++
 tb/tb_fx_bus_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus: widths, mod_id field position
// and the arbiter state encoding.
package fx_pkg;

    localparam int FX_AW        = 16;
    localparam int FX_DW        = 8;
    localparam int FX_MODID_MSB = 13;
    localparam int FX_MODID_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } fx_arb_state_t;

endpackage

// File: rtl/fx_rr_pick.sv
// Combinational round-robin selector: searches from ptr+1 upward, wrapping
// at NREQ-1, and returns a one-hot grant plus its binary index.
module fx_rr_pick
    import fx_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int  c;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        // k runs 1..NREQ so the current pointer holder is checked last
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fx_bus_arb.sv
// Round-robin arbiter/sequencer for the shared fx register bus: one
// single-byte write (3 cycles) or read (4 cycles) per grant.
module fx_bus_arb
    import fx_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_we,
    input  logic [FX_AW*NREQ-1:0] req_addr,
    input  logic [FX_DW*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]       ack,
    output logic [FX_DW-1:0]      rdata,
    output logic [FX_AW-1:0]      fx_waddr,
    output logic                  fx_wr,
    output logic [FX_DW-1:0]      fx_data,
    output logic [FX_AW-1:0]      fx_raddr,
    output logic                  fx_rd,
    input  logic [FX_DW-1:0]      fx_q,
    output logic                  busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    fx_arb_state_t   state, state_nxt;
    logic [PW-1:0]   ptr, win, pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic            any_req, lat_we, grant;
    logic            sel_we;
    logic [FX_AW-1:0] sel_addr;
    logic [FX_DW-1:0] sel_wdata;

    fx_rr_pick #(.NREQ(NREQ), .IW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign any_req   = |pick_gnt;
    assign grant     = (state == ST_IDLE) && any_req;
    assign sel_we    = req_we[pick_idx];
    assign sel_addr  = req_addr[int'(pick_idx)*FX_AW +: FX_AW];
    assign sel_wdata = req_wdata[int'(pick_idx)*FX_DW +: FX_DW];

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes and ack are decoded from state so reset clears them at once
    always_comb begin
        state_nxt = state;
        fx_wr     = 1'b0;
        fx_rd     = 1'b0;
        ack       = '0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                fx_wr     = lat_we;
                fx_rd     = !lat_we;
                state_nxt = lat_we ? ST_ACK : ST_WAIT;
            end
            ST_WAIT:  state_nxt = ST_ACK;
            ST_ACK: begin
                ack[win]  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ptr      <= PW'(NREQ - 1);
            win      <= '0;
            lat_we   <= 1'b0;
            fx_waddr <= '0;
            fx_raddr <= '0;
            fx_data  <= '0;
            rdata    <= '0;
        end else begin
            if (grant) begin
                ptr    <= pick_idx;
                win    <= pick_idx;
                lat_we <= sel_we;
                // Write and read address ports only move on their own grant type
                if (sel_we) begin
                    fx_waddr <= sel_addr;
                    fx_data  <= sel_wdata;
                end else begin
                    fx_raddr <= sel_addr;
                end
            end
            if (state == ST_WAIT) begin
                rdata <= fx_q;
            end
        end
    end

endmodule

// File: tb/tb_fx_bus_arb.sv
// Directed bench for fx_bus_arb with a registered slave model behind the bus.
module tb_fx_bus_arb;

    localparam int NREQ = 3;

    logic              clk_sys = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, req_we, ack;
    logic [16*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [7:0]        rdata, fx_data, fx_q;
    logic [15:0]       fx_waddr, fx_raddr;
    logic              fx_wr, fx_rd, busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:7];

    fx_bus_arb #(.NREQ(NREQ)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .fx_waddr  (fx_waddr),
        .fx_wr     (fx_wr),
        .fx_data   (fx_data),
        .fx_raddr  (fx_raddr),
        .fx_rd     (fx_rd),
        .fx_q      (fx_q),
        .busy      (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Slave: 0x0200 is an ID register reading 0x02, 0x0280-0x0287 are RAM,
    // everything else is unmapped and reads 0.
    function automatic logic [7:0] slave_rd(input logic [15:0] a);
        if (a == 16'h0200) return 8'h02;
        if (a[15:3] == 13'h0050) return mem[a[2:0]];
        return 8'h00;
    endfunction

    always @(posedge clk_sys) begin
        fx_q <= fx_rd ? slave_rd(fx_raddr) : 8'h00;
        if (fx_wr && fx_waddr[15:3] == 13'h0050) mem[fx_waddr[2:0]] <= fx_data;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [7:0] d);
        req_we[i]           = we;
        req_addr[16*i +: 16] = a;
        req_wdata[8*i +: 8]  = d;
        req[i]              = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, last, w;
        logic [2:0] exp_ack;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        fx_q      = 8'h00;
        rst       = 1'b1;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {fx_wr, fx_rd}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", {fx_waddr, fx_raddr, fx_data}, 0);
        tick(); tick();
        rst = 1'b0;

        // Single write: req0 writes 0x5A to 0x0283
        set_req(0, 1'b1, 16'h0283, 8'h5A);
        tick();
        chk("wr_strobe", {fx_wr, fx_rd}, 2'b10);
        chk("wr_addr", fx_waddr, 16'h0283);
        chk("wr_data", fx_data, 8'h5A);
        chk("wr_busy_noack", {busy, ack}, 4'b1000);
        tick();
        chk("wr_ack", ack, 3'b001);
        chk("wr_strobe_off", {fx_wr, fx_rd}, 0);
        req = '0;
        tick();
        chk("wr_idle", {busy, ack}, 0);
        chk("wr_addr_hold", fx_waddr, 16'h0283);

        // Single read: req1 reads 0x0200
        set_req(1, 1'b0, 16'h0200, 8'h00);
        tick();
        chk("rd_strobe", {fx_wr, fx_rd}, 2'b01);
        chk("rd_addr", fx_raddr, 16'h0200);
        chk("rd_waddr_kept", fx_waddr, 16'h0283);
        tick();
        chk("rd_wait", {fx_rd, ack}, 0);
        tick();
        chk("rd_ack", ack, 3'b010);
        chk("rd_data", rdata, 8'h02);
        req = '0;
        tick(); tick();
        chk("rd_data_hold", rdata, 8'h02);

        // Fairness: pointer back to reset value, all three hold read requests
        rst = 1'b1; #1; rst = 1'b0;
        set_req(0, 1'b0, 16'h0200, 8'h00);
        set_req(1, 1'b0, 16'h0288, 8'h00);
        set_req(2, 1'b0, 16'h0200, 8'h00);
        cyc  = 0;
        last = 0;
        for (int n = 0; n < 6; n++) begin
            w = 0;
            while (ack == 0 && w < 20) begin
                tick(); cyc++; w++;
            end
            exp_ack = 3'b001 << (n % 3);
            chk("fair_ack", ack, exp_ack);
            chk("fair_rdata", rdata, (n % 3 == 1) ? 8'h00 : 8'h02);
            if (n > 0) chk("fair_gap", cyc - last, 4);
            last = cyc;
            if (n == 5) req = '0;
            tick(); cyc++;
        end
        chk("fair_idle", busy, 0);

        // Write then read back through req2, then an unmapped read
        set_req(2, 1'b1, 16'h0285, 8'hC3);
        tick();
        chk("wtr_wr", {fx_wr, fx_waddr, fx_data}, {1'b1, 16'h0285, 8'hC3});
        tick();
        chk("wtr_wack", ack, 3'b100);
        req_we[2] = 1'b0;
        tick(); tick();
        chk("wtr_rd", {fx_rd, fx_raddr}, {1'b1, 16'h0285});
        tick(); tick();
        chk("wtr_rack", ack, 3'b100);
        chk("wtr_rdata", rdata, 8'hC3);
        req_addr[32 +: 16] = 16'h0288;
        tick(); tick(); tick(); tick();
        chk("unmap_ack", ack, 3'b100);
        chk("unmap_rdata", rdata, 8'h00);
        req = '0;
        tick();

        // Abort-immune: req0 drops in the ISSUE cycle
        set_req(0, 1'b1, 16'h0281, 8'h11);
        tick();
        chk("ab_wr", fx_wr, 1);
        req = '0;
        tick();
        chk("ab_ack", {fx_wr, ack}, 4'b0001);
        tick();
        chk("ab_idle", {busy, fx_wr, fx_rd, ack}, 0);
        tick();
        chk("ab_nodup", {busy, fx_wr, fx_rd}, 0);
        chk("ab_mem", mem[1], 8'h11);

        // Reset during WAIT, request kept pending
        set_req(1, 1'b0, 16'h0200, 8'h00);
        tick(); tick();
        chk("rr_in_wait", {busy, fx_rd}, 2'b10);
        rst = 1'b1;
        #1;
        chk("rr_async", {busy, fx_wr, fx_rd, ack, rdata}, 0);
        chk("rr_addr", {fx_waddr, fx_raddr, fx_data}, 0);
        tick();
        chk("rr_noack", ack, 0);
        rst = 1'b0;
        tick();
        chk("rr_regrant", {fx_rd, fx_raddr}, {1'b1, 16'h0200});
        tick(); tick();
        chk("rr_ack", ack, 3'b010);
        chk("rr_rdata", rdata, 8'h02);
        req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
